// File: rtl/mem_responder.sv
// mem_responder: main-memory side of the cache line-fill / writeback interface.
// Accepts one line request at a time, stores writeback words into a
// word-addressed synchronous array, and returns fill lines as a gap-free
// burst after a fixed access latency.
module mem_responder #(
   parameter int ADDR_W         = 16,
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int LATENCY        = 4,
   parameter int DEPTH_WORDS    = 1024
) (
   input  logic              clk,
   input  logic              rst_n,      // synchronous, active-high despite the name
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic              resp_done
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int MEM_AW = $clog2(DEPTH_WORDS);
   localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(WORDS_PER_LINE - 1);
   localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_COLLECT,
      ST_WAIT,
      ST_RD_BURST,
      ST_DONE
   } state_t;

   state_t             state_reg, state_next;
   logic               we_reg, we_next;
   logic [MEM_AW-1:0]  base_reg, base_next;
   logic [OFF_W-1:0]   word_cnt_reg, word_cnt_next;
   logic [LAT_W-1:0]   lat_cnt_reg, lat_cnt_next;
   logic               ready_en_reg;

   // storage and its control
   logic [DATA_W-1:0]  mem [0:DEPTH_WORDS-1];
   logic [DATA_W-1:0]  mem_q;
   logic               mem_we;
   logic               mem_re;
   logic [MEM_AW-1:0]  mem_waddr;
   logic [MEM_AW-1:0]  mem_raddr;

   // combinational outputs of the FSM
   logic               req_ready_c;
   logic               wr_ready_c;
   logic               rd_valid_c;
   logic               rd_last_c;
   logic               resp_done_c;

   // Line-aligned base; upper address bits beyond the depth alias away.
   logic [MEM_AW-1:0]  req_base;
   assign req_base = {req_addr[MEM_AW-1:OFF_W], {OFF_W{1'b0}}};

   // Offset bits and bits above the storage depth are intentionally dropped.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr;

   // State and transaction registers; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_reg    <= ST_IDLE;
         we_reg       <= 1'b0;
         base_reg     <= '0;
         word_cnt_reg <= '0;
         lat_cnt_reg  <= '0;
         ready_en_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         we_reg       <= we_next;
         base_reg     <= base_next;
         word_cnt_reg <= word_cnt_next;
         lat_cnt_reg  <= lat_cnt_next;
         ready_en_reg <= 1'b1;
      end
   end

   // Next-state, counters, memory control and handshake outputs.
   always_comb begin
      state_next    = state_reg;
      we_next       = we_reg;
      base_next     = base_reg;
      word_cnt_next = word_cnt_reg;
      lat_cnt_next  = lat_cnt_reg;
      req_ready_c   = 1'b0;
      wr_ready_c    = 1'b0;
      rd_valid_c    = 1'b0;
      rd_last_c     = 1'b0;
      resp_done_c   = 1'b0;
      mem_we        = 1'b0;
      mem_re        = 1'b0;
      mem_waddr     = base_reg + MEM_AW'(word_cnt_reg);
      mem_raddr     = base_reg + MEM_AW'(word_cnt_reg) + MEM_AW'(1);

      case (state_reg)
         ST_IDLE: begin
            // held low for the first cycle out of reset
            req_ready_c = ready_en_reg;
            if (req_valid && ready_en_reg) begin
               we_next       = req_we;
               base_next     = req_base;
               word_cnt_next = '0;
               lat_cnt_next  = '0;
               state_next    = req_we ? ST_WR_COLLECT : ST_WAIT;
            end
         end

         ST_WR_COLLECT: begin
            wr_ready_c = 1'b1;
            if (wr_valid) begin
               mem_we = 1'b1;
               if (word_cnt_reg == WORD_LAST) begin
                  word_cnt_next = '0;
                  lat_cnt_next  = '0;
                  state_next    = ST_WAIT;
               end else begin
                  word_cnt_next = word_cnt_reg + OFF_W'(1);
               end
            end
         end

         ST_WAIT: begin
            if (lat_cnt_reg == LAT_LAST) begin
               lat_cnt_next = '0;
               if (we_reg) begin
                  state_next = ST_DONE;
               end else begin
                  // prefetch word 0 so the burst starts without a bubble
                  state_next    = ST_RD_BURST;
                  word_cnt_next = '0;
                  mem_re        = 1'b1;
                  mem_raddr     = base_reg;
               end
            end else begin
               lat_cnt_next = lat_cnt_reg + LAT_W'(1);
            end
         end

         ST_RD_BURST: begin
            rd_valid_c = 1'b1;
            if (word_cnt_reg == WORD_LAST) begin
               rd_last_c     = 1'b1;
               word_cnt_next = '0;
               state_next    = ST_DONE;
            end else begin
               // fetch the word shown on the next burst cycle
               word_cnt_next = word_cnt_reg + OFF_W'(1);
               mem_re        = 1'b1;
            end
         end

         ST_DONE: begin
            resp_done_c = 1'b1;
            state_next  = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Word-addressed storage with registered read; not cleared by reset.
   always_ff @(posedge clk) begin
      if (mem_we && !rst_n) begin
         mem[mem_waddr] <= wr_data;
      end
      if (mem_re) begin
         mem_q <= mem[mem_raddr];
      end
   end

   assign req_ready = req_ready_c;
   assign wr_ready  = wr_ready_c;
   assign rd_valid  = rd_valid_c;
   assign rd_last   = rd_last_c;
   assign resp_done = resp_done_c;
   // data bus is quiet outside the burst
   assign rd_data   = rd_valid_c ? mem_q : '0;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder. Expected fill words
// come from a bench-side model of the storage, are queued when a read is
// accepted and compared as the burst appears.
module tb_mem_responder;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 32;
   localparam int WPL     = 4;
   localparam int LATENCY = 4;
   localparam int DEPTH   = 1024;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic              wr_valid;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ready;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_data;
   logic              rd_last;
   logic              resp_done;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] model_mem [0:DEPTH-1];
   logic [32:0]       exp_q [$];
   logic [32:0]       mon_e;

   mem_responder #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_LINE(WPL),
      .LATENCY(LATENCY), .DEPTH_WORDS(DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
      .resp_done(resp_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int line_base(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] a;
      a = {addr[ADDR_W-1:2], 2'b00};
      return int'(a) % DEPTH;
   endfunction

   task automatic push_line(input logic [ADDR_W-1:0] addr);
      int b;
      b = line_base(addr);
      for (int i = 0; i < WPL; i++) begin
         exp_q.push_back({(i == WPL - 1), model_mem[(b + i) % DEPTH]});
      end
      $display("read  addr=%h base=%h queued %0d words", addr, b, WPL);
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         step();
         n++;
      end
      check_eq("ready_wait", req_ready, 1);
   endtask

   // Waits out latency, burst and completion after a read has been accepted.
   task automatic wait_burst();
      int n;
      n = 0;
      while (rd_valid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check_eq("rd_latency", n, LATENCY);
      while (resp_done !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      check_eq("rd_done_cycle", n, LATENCY + WPL);
      check_eq("rd_queue_empty", exp_q.size(), 0);
      step();
      check_eq("rd_done_pulse", resp_done, 0);
      check_eq("rd_ready_back", req_ready, 1);
   endtask

   task automatic rd_line(input logic [ADDR_W-1:0] addr);
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = addr;
      step();
      req_valid = 1'b0;
      push_line(addr);
      wait_burst();
   endtask

   // pat: one bit per collect cycle (LSB first); last used bit must be 1.
   task automatic wr_line(input logic [ADDR_W-1:0] addr, input logic [WPL-1:0][DATA_W-1:0] words,
                          input logic [15:0] pat, input int npat, input logic junk);
      int b;
      int k;
      int n;
      b = line_base(addr);
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = addr;
      step();
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 16'hFFFF;
      k = 0;
      for (int c = 0; c < npat; c++) begin
         check_eq("wr_ready_on", wr_ready, 1);
         wr_valid = pat[c];
         wr_data  = pat[c] ? words[k] : (32'hBAD0_0000 + c);
         step();
         if (pat[c]) begin
            model_mem[(b + k) % DEPTH] = words[k];
            k++;
         end
      end
      // words presented outside the collect phase must be ignored
      wr_valid = junk;
      wr_data  = 32'hDEAD_BEEF;
      check_eq("wr_ready_off", wr_ready, 0);
      n = 0;
      while (resp_done !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check_eq("wr_latency", n, LATENCY);
      wr_valid = 1'b0;
      step();
      check_eq("wr_done_pulse", resp_done, 0);
      check_eq("wr_ready_back", req_ready, 1);
      $display("write addr=%h base=%h words=%0d cycles=%0d", addr, b, k, npat);
   endtask

   // Scoreboard side: compare each fill word as it appears.
   always @(negedge clk) begin
      if (rd_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check_eq("rd_unexpected", rd_valid, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check_eq("rd_data", rd_data, mon_e[31:0]);
            check_eq("rd_last", rd_last, 32'(mon_e[32]));
            $display("fill  data=%h last=%b", rd_data, rd_last);
         end
      end else if (rd_last === 1'b1) begin
         check_eq("rd_last_idle", rd_valid, 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      wr_valid  = 1'b0;
      wr_data   = '0;
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;

      // reset state
      repeat (3) step();
      check_eq("rst_req_ready", req_ready, 0);
      check_eq("rst_wr_ready", wr_ready, 0);
      check_eq("rst_rd_valid", rd_valid, 0);
      check_eq("rst_rd_last", rd_last, 0);
      check_eq("rst_rd_data", rd_data, 0);
      check_eq("rst_resp_done", resp_done, 0);
      rst_n = 1'b0;
      step();
      check_eq("rst_ready_after", req_ready, 1);
      $display("reset done");

      // back-to-back write, then unaligned read-back
      wr_line(16'h0010, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 16'b1111, 4, 1'b0);
      rd_line(16'h0013);

      // gapped write with junk words during latency, then read-back
      wr_line(16'h0020, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'b1011001, 7, 1'b1);
      rd_line(16'h0022);

      // aliasing above the storage depth
      wr_line(16'h0400, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 16'b1111, 4, 1'b0);
      rd_line(16'h0000);

      // second request held during a busy read
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0010;
      step();
      push_line(16'h0010);
      req_addr = 16'h0021;
      n = 0;
      while (resp_done !== 1'b1 && n < 100) begin
         check_eq("busy_ready", req_ready, 0);
         step();
         n++;
      end
      check_eq("busy_done_cycle", n, LATENCY + WPL);
      check_eq("busy_done_ready", req_ready, 0);
      step();
      check_eq("held_ready", req_ready, 1);
      step();
      req_valid = 1'b0;
      push_line(16'h0021);
      wait_burst();

      // reset during the second fill word
      wait_ready();
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 16'h0020;
      step();
      req_valid = 1'b0;
      push_line(16'h0020);
      n = 0;
      while (rd_valid !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      check_eq("abort_latency", n, LATENCY);
      step();
      rst_n = 1'b1;
      step();
      rst_n = 1'b0;
      exp_q.delete();
      check_eq("abort_rd_valid", rd_valid, 0);
      check_eq("abort_rd_last", rd_last, 0);
      check_eq("abort_resp_done", resp_done, 0);
      check_eq("abort_req_ready", req_ready, 0);
      step();
      check_eq("abort_ready_after", req_ready, 1);
      $display("reset during burst done");
      rd_line(16'h0010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
